// File: rtl/inst_issue_unit.sv
`default_nettype none
// inst_issue_unit: fetches opcodes from a program ROM into a prefetch FIFO and issues them to the CU with stall handshake.
// Optional feature macro PERF_CNT_EN adds perf_issued/perf_stall run counters.  Rev 1.0
module inst_issue_unit #(
  parameter int ADDR_W     = 4,
  parameter int INST_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        count,
  output logic              prog_rd,
  output logic [ADDR_W-1:0] prog_addr,
  input  logic [INST_W-1:0] prog_data,
  input  logic              stall,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              busy,
  output logic              done
`ifdef PERF_CNT_EN
  ,
  output logic [7:0]        perf_issued,
  output logic [15:0]       perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0]    c_depth = (OCC_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_start = ADDR_W'(START_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [7:0]          r_count;
  logic [7:0]          r_fetched;
  logic [7:0]          r_issued;
  logic                r_inflight;
  logic [INST_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [OCC_W-1:0]    r_occ;
  logic [INST_W-1:0]   r_inst;
  logic                r_inst_valid;

  logic                w_start_acc;
  logic                w_busy;
  logic                w_done;
  logic [OCC_W:0]      w_occ_sum;
  logic                w_rd;
  logic                w_push;
  logic                w_pop;
  logic                w_consume;

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = (count == 8'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if ((r_issued == r_count) && !r_inst_valid) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A slot is reserved for each read in flight, so the FIFO can never overflow.
  assign w_occ_sum = {1'b0, r_occ} + {{OCC_W{1'b0}}, r_inflight};
  assign w_rd      = (r_state == S_RUN) && (r_fetched < r_count) && (w_occ_sum < c_depth);
  assign w_push    = r_inflight;
  assign w_consume = r_inst_valid && !stall;
  assign w_pop     = (!r_inst_valid || !stall) && (r_occ != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= c_start;
      r_count      <= 8'd0;
      r_fetched    <= 8'd0;
      r_issued     <= 8'd0;
      r_inflight   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_occ        <= '0;
      r_inst       <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd;
      if (w_start_acc) begin
        r_count   <= count;
        r_fetched <= 8'd0;
        r_issued  <= 8'd0;
        r_pc      <= c_start;
      end else begin
        if (w_rd) begin
          r_pc      <= r_pc + ADDR_W'(1);
          r_fetched <= r_fetched + 8'd1;
        end
        if (w_consume) r_issued <= r_issued + 8'd1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      // Output register refills from the FIFO head whenever it is empty or being consumed.
      if (w_pop) begin
        r_inst       <= r_mem[r_rd_ptr];
        r_inst_valid <= 1'b1;
      end else if (w_consume) begin
        r_inst_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= prog_data;
  end

  assign prog_rd    = w_rd;
  assign prog_addr  = r_pc;
  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign busy       = w_busy;
  assign done       = w_done;

`ifdef PERF_CNT_EN
  logic [7:0]  r_perf_issued;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_issued <= 8'd0;
      r_perf_stall  <= 16'd0;
    end else if (w_start_acc) begin
      r_perf_issued <= 8'd0;
      r_perf_stall  <= 16'd0;
    end else if (r_state == S_RUN) begin
      if (w_consume) r_perf_issued <= r_perf_issued + 8'd1;
      if (r_inst_valid && stall && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_issue_unit.sv
`default_nettype none
// tb_inst_issue_unit: directed self-checking bench for inst_issue_unit with a ROM[a]=a program model.
// Run counter checks are compiled in when PERF_CNT_EN is defined.
module tb_inst_issue_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic       prog_rd;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;
  logic       stall;
  logic [3:0] inst;
  logic       inst_valid;
  logic       busy;
  logic       done;
`ifdef PERF_CNT_EN
  logic [7:0]  perf_issued;
  logic [15:0] perf_stall;
`endif

  inst_issue_unit #(
    .ADDR_W(4), .INST_W(4), .FIFO_DEPTH(4), .START_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .prog_rd(prog_rd), .prog_addr(prog_addr), .prog_data(prog_data),
    .stall(stall), .inst(inst), .inst_valid(inst_valid),
    .busy(busy), .done(done)
`ifdef PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [3:0] rom [16];
  always @(posedge clk) begin
    if (prog_rd) prog_data <= rom[prog_addr];
  end

  logic [3:0] got_q [$];
  int n_rd;
  int n_stall;
  always @(negedge clk) begin
    if (inst_valid && !stall) got_q.push_back(inst);
    if (inst_valid && stall) n_stall++;
    if (prog_rd) n_rd++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_rd    = 0;
    n_stall = 0;
  endtask

  task automatic do_start(input logic [7:0] c);
    start = 1'b1;
    count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 300) begin
      tick();
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int n);
    logic [31:0] v;
    check({tag, " count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      v = (i < got_q.size()) ? 32'(got_q[i]) : 'x;
      check({tag, " seq"}, v, 32'(i % 16));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " inst_valid"}, 32'(inst_valid), 32'd0);
    check({tag, " inst"}, 32'(inst), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " prog_rd"}, 32'(prog_rd), 32'd0);
    check({tag, " prog_addr"}, 32'(prog_addr), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 16; a++) rom[a] = 4'(a);
    rst = 1'b1; start = 1'b0; count = 8'd0; stall = 1'b0;
    clear_mon();
    #1;
    check_idle_outputs("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: 16 opcodes, no stall, exact latency and throughput
    clear_mon();
    do_start(8'd16);
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 prog_rd", 32'(prog_rd), 32'd1);
    check("t1 valid T0", 32'(inst_valid), 32'd0);
    tick();
    check("t1 valid T1", 32'(inst_valid), 32'd0);
    tick();
    check("t1 valid T2", 32'(inst_valid), 32'd0);
    tick();
    check("t1 valid T3", 32'(inst_valid), 32'd1);
    check("t1 inst0", 32'(inst), 32'd0);
    for (int k = 1; k < 16; k++) begin
      tick();
      check("t1 stream valid", 32'(inst_valid), 32'd1);
      check("t1 stream inst", 32'(inst), 32'(k));
    end
    tick();
    check("t1 valid drop", 32'(inst_valid), 32'd0);
    check("t1 inst kept", 32'(inst), 32'd15);
    tick();
    check("t1 done", 32'(done), 32'd1);
    check("t1 busy end", 32'(busy), 32'd0);
    check_seq("t1", 16);

    // 2: stall for 5 cycles while inst=2 is presented
    clear_mon();
    do_start(8'd16);
    tick(); tick(); tick(); tick(); tick();
    check("t2 pre-stall inst", 32'(inst), 32'd2);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2 hold inst", 32'(inst), 32'd2);
      check("t2 hold valid", 32'(inst_valid), 32'd1);
    end
    check("t2 prog_rd stopped", 32'(prog_rd), 32'd0);
    stall = 1'b0;
    wait_done("t2");
    check_seq("t2", 16);

    // 3: PC wrap over 20 opcodes
    clear_mon();
    do_start(8'd20);
    wait_done("t3");
    check_seq("t3", 20);
    check("t3 reads", 32'(n_rd), 32'd20);

    // 5: async reset mid-run after 7 issues, then a fresh run
    clear_mon();
    do_start(8'd16);
    for (int k = 0; k < 100 && got_q.size() < 7; k++) tick();
    check("t5 issued before rst", 32'(got_q.size()), 32'd7);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("t5 rst");
    #1 rst = 1'b0;
    tick();
    clear_mon();
    do_start(8'd4);
    wait_done("t5");
    check_seq("t5", 4);

    // 4: count=0 straight to done from a clean reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("t4 done pre", 32'(done), 32'd0);
    clear_mon();
    do_start(8'd0);
    check("t4 done", 32'(done), 32'd1);
    check("t4 busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("t4 reads", 32'(n_rd), 32'd0);
    check("t4 issued", 32'(got_q.size()), 32'd0);

`ifdef PERF_CNT_EN
    // 6: run counters with alternating stall
    clear_mon();
    do_start(8'd8);
    for (int k = 0; k < 300 && !done; k++) begin
      stall = ~stall;
      tick();
    end
    stall = 1'b0;
    check("t6 done", 32'(done), 32'd1);
    check_seq("t6", 8);
    check("t6 perf_issued", 32'(perf_issued), 32'd8);
    check("t6 perf_stall", 32'(perf_stall), 32'(n_stall));
    check("t6 stalls seen", 32'(n_stall > 0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
